// File: rtl/handshake_issue.sv
// Write-side issue stage: FIFO-buffers packets and presents them one at a time
// on a four-phase req/ack handshake, with ack synchronised into the clk domain.
module handshake_issue #(
  parameter int unsigned WIDTH       = 42,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             req,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack,
  output logic             busy,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } state_t;

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W:0]         count_q;
  logic [PTR_W:0]         count_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  state_t                 state_q;
  logic                   req_q;
  logic [WIDTH-1:0]       data_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   push;
  logic                   pop;

  assign ack_s    = sync_q[SYNC_STAGES-1];
  assign in_ready = (count_q != FULL);
  assign push     = in_valid && in_ready;
  // The pop is the IDLE->REQ transition itself, so it shares the FSM's condition.
  assign pop      = (state_q == IDLE) && (count_q != '0) && !ack_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            data_q  <= mem_q[rd_ptr_q];
          end
        end
        REQ: begin
          if (ack_s) begin
            state_q <= RELEASE;
            req_q   <= 1'b0;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req      = req_q;
  assign data_out = data_q;
  assign sent_cnt = cnt_q;
  assign busy     = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_handshake_issue.sv
// Directed bench for handshake_issue: reset, single packet, back-pressure,
// simultaneous push/pop, mid-handshake reset and sent-counter wrap (CNT_W=4).
module tb_handshake_issue;

  localparam int unsigned WIDTH = 42;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             req;
  logic [WIDTH-1:0] data_out;
  logic             ack;
  logic             busy;
  logic [CNT_W-1:0] sent_cnt;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  handshake_issue #(
    .WIDTH(WIDTH),
    .DEPTH(4),
    .SYNC_STAGES(2),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .req(req),
    .data_out(data_out),
    .ack(ack),
    .busy(busy),
    .sent_cnt(sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ack responder: ack rises 2 edges after req is seen, held high for 5 edges.
  task automatic hs(input logic [WIDTH-1:0] d, input int unsigned c_exp, input string tag);
    int unsigned w = 0;
    while (req !== 1'b1 && w < 20) begin
      step(1);
      w++;
    end
    chk({tag, "_req_up"}, 64'(req), 64'd1);
    chk({tag, "_data"}, 64'(data_out), 64'(d));
    step(2);
    ack = 1'b1;
    step(2);
    chk({tag, "_req_hold"}, 64'(req), 64'd1);
    chk({tag, "_data_hold"}, 64'(data_out), 64'(d));
    step(1);
    chk({tag, "_req_fall"}, 64'(req), 64'd0);
    chk({tag, "_cnt"}, 64'(sent_cnt), 64'(c_exp));
    step(2);
    ack = 1'b0;
    step(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ack      = 1'b1;

    // Reset with ack high
    step(2);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cnt", 64'(sent_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    step(3);
    in_valid = 1'b1;
    in_data  = 42'h11;
    step(1);
    in_valid = 1'b0;
    step(3);
    chk("ackhi_req", 64'(req), 64'd0);
    chk("ackhi_busy", 64'(busy), 64'd1);
    ack = 1'b0;
    step(2);
    chk("acklo_sync_req", 64'(req), 64'd0);
    step(1);
    chk("acklo_req", 64'(req), 64'd1);
    hs(42'h11, 1, "first");

    // Single packet, fill latency
    in_valid = 1'b1;
    in_data  = 42'h2A_DEAD_BEEF;
    step(1);
    in_valid = 1'b0;
    chk("single_e0_req", 64'(req), 64'd0);
    step(1);
    chk("single_e1_req", 64'(req), 64'd1);
    chk("single_e1_data", 64'(data_out), 64'h2A_DEAD_BEEF);
    hs(42'h2A_DEAD_BEEF, 2, "single");
    chk("single_busy", 64'(busy), 64'd0);
    chk("single_data_kept", 64'(data_out), 64'h2A_DEAD_BEEF);

    // Back-pressure: ack_s high keeps the FSM in IDLE while the FIFO fills
    ack = 1'b1;
    step(2);
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      chk("bp_in_ready", 64'(in_ready), (i <= 4) ? 64'd1 : 64'd0);
      step(1);
    end
    in_valid = 1'b0;
    chk("bp_full", 64'(in_ready), 64'd0);
    chk("bp_no_req", 64'(req), 64'd0);
    ack = 1'b0;
    step(2);
    chk("bp_pop_cycle_ready", 64'(in_ready), 64'd0);
    chk("bp_pop_cycle_req", 64'(req), 64'd0);
    step(1);
    chk("bp_req", 64'(req), 64'd1);
    chk("bp_data", 64'(data_out), 64'd1);
    chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
    hs(42'd1, 3, "bp1");
    hs(42'd2, 4, "bp2");
    hs(42'd3, 5, "bp3");
    hs(42'd4, 6, "bp4");
    step(3);
    chk("bp_drained_req", 64'(req), 64'd0);
    chk("bp_drained_busy", 64'(busy), 64'd0);

    // Simultaneous push/pop with count=2
    ack = 1'b1;
    step(2);
    in_valid = 1'b1;
    in_data  = 42'h2AA_AAAA_AAAA;
    step(1);
    in_data  = 42'h155_5555_5555;
    step(1);
    in_valid = 1'b0;
    ack = 1'b0;
    step(2);
    in_valid = 1'b1;
    in_data  = 42'h3FF_FFFF_FFFF;
    chk("pp_ready_before", 64'(in_ready), 64'd1);
    step(1);
    chk("pp_req", 64'(req), 64'd1);
    chk("pp_data", 64'(data_out), 64'h2AA_AAAA_AAAA);
    chk("pp_ready_after", 64'(in_ready), 64'd1);
    in_data = 42'h0DD;
    step(1);
    chk("pp_count3_ready", 64'(in_ready), 64'd1);
    in_data = 42'h0EE;
    step(1);
    chk("pp_count4_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    hs(42'h2AA_AAAA_AAAA, 7, "ppA");
    hs(42'h155_5555_5555, 8, "ppB");
    hs(42'h3FF_FFFF_FFFF, 9, "ppC");
    hs(42'h0DD, 10, "ppD");
    hs(42'h0EE, 11, "ppE");

    // Reset during REQ with 3 queued
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = WIDTH'(32'h100 + i);
      step(1);
    end
    in_valid = 1'b0;
    chk("mid_req_before", 64'(req), 64'd1);
    chk("mid_data_before", 64'(data_out), 64'h101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(req), 64'd0);
    chk("mid_rst_data", 64'(data_out), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_cnt", 64'(sent_cnt), 64'd0);
    step(2);
    rst_n = 1'b1;
    step(10);
    chk("mid_after_req", 64'(req), 64'd0);
    chk("mid_after_busy", 64'(busy), 64'd0);
    chk("mid_after_ready", 64'(in_ready), 64'd1);
    chk("mid_after_cnt", 64'(sent_cnt), 64'd0);

    // Counter wrap at 2^CNT_W
    for (int i = 1; i <= 17; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(32'h3F0 + i);
      step(1);
      in_valid = 1'b0;
      hs(WIDTH'(32'h3F0 + i), i % 16, "wrap");
    end
    chk("wrap_final", 64'(sent_cnt), 64'd1);
    chk("wrap_idle_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
